// File: rtl/poly_add_seq_if.sv
// Handshake and operand/result bus for poly_add_seq: 256 packed 32-bit coefficients per operand.
interface poly_add_seq_if;
  localparam int W = 32 * 256;

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] c_out;

  modport master (output start, output a_in, output b_in,
                  input  busy,  input  done, input  c_out);
  modport slave  (input  start, input  a_in, input  b_in,
                  output busy,  output done, output c_out);
endinterface

// File: rtl/poly_add_seq.sv
// Sequential coefficient-wise adder c = a + b, LANES coefficients per clock under start/busy/done.
// Define POLY_ADD_REDUCE_EN to reduce each sum mod Q (inputs assumed in [0, Q-1]).
module poly_add_seq #(
  parameter int LANES = 8
`ifdef POLY_ADD_REDUCE_EN
  , parameter int Q = 8380417
`endif
) (
  input  logic          clk,
  input  logic          rst,
  poly_add_seq_if.slave bus
);
  localparam int N      = 256;
  localparam int CHW    = 32 * LANES;
  localparam int NCHUNK = N / LANES;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en;

  logic [CHW-1:0]  a_chunks [NCHUNK];
  logic [CHW-1:0]  b_chunks [NCHUNK];
  logic [CHW-1:0]  c_q      [NCHUNK];
  logic [CHW-1:0]  a_sel, b_sel, sum_chunk;
  logic [32*N-1:0] c_flat;

  always_comb begin
    for (int k = 0; k < NCHUNK; k++) begin
      a_chunks[k] = bus.a_in[k*CHW +: CHW];
      b_chunks[k] = bus.b_in[k*CHW +: CHW];
    end
  end

  // Operands are read live per chunk; the caller holds them stable until done.
  assign a_sel = a_chunks[cnt_q];
  assign b_sel = b_chunks[cnt_q];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [31:0] a_l, b_l;
    assign a_l = a_sel[gi*32 +: 32];
    assign b_l = b_sel[gi*32 +: 32];
`ifdef POLY_ADD_REDUCE_EN
    logic [32:0] s_l;
    assign s_l = {1'b0, a_l} + {1'b0, b_l};
    assign sum_chunk[gi*32 +: 32] = (s_l >= 33'(Q)) ? 32'(s_l - 33'(Q)) : s_l[31:0];
`else
    assign sum_chunk[gi*32 +: 32] = a_l + b_l;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCHUNK; k++) c_q[k] <= '0;
    end else if (wr_en) begin
      c_q[cnt_q] <= sum_chunk;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        wr_en = 1'b1;
        // Natural wrap leaves the counter at 0 when the last chunk is written.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    c_flat = '0;
    for (int k = 0; k < NCHUNK; k++) c_flat[k*CHW +: CHW] = c_q[k];
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.c_out = c_flat;
endmodule
